lab3_mem_responder: RTL and testbench

Pipelined memory responder that forms the memory-side end of the cache refill/evict port. It accepts `mem_req_4B_t` requests from a cache controller's `cache_req` interface and returns `mem_resp_4B_t` responses in order after a fixed latency. It holds a word-addressed backing store and bounds outstanding requests with an internal credit count. It serves as the main-memory stand-in under the cache in both unit and system benches.

---
 rtl/lab3_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_lab3_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_mem_responder.sv
// ============================================================================
// lab3_mem_responder : fixed-latency, in-order memory responder with credits
// Revision: 1.0
// ============================================================================
`default_nettype none

package lab3_mem_pkg;
    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;
endpackage

module lab3_mem_responder
    import lab3_mem_pkg::*;
#(
    parameter int p_num_words   = 256,
    parameter int p_latency     = 2,
    parameter int p_queue_depth = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  mem_req_4B_t  memreq_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output mem_resp_4B_t memresp_msg
);
    localparam int IDX_W = $clog2(p_num_words);
    localparam int CNT_W = $clog2(p_queue_depth + 1);
    localparam int PTR_W = $clog2(p_queue_depth);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(p_queue_depth);
    localparam logic [PTR_W-1:0] c_LAST  = PTR_W'(p_queue_depth - 1);

    logic [31:0]      mem_q [p_num_words];
    mem_resp_4B_t     fifo_q [p_queue_depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, outstanding_q, outstanding_d;
    logic             rdy_en_q;

    logic             w_accept, w_deliver, w_is_write, w_push;
    logic [IDX_W-1:0] w_idx;
    int               w_lo, w_n;
    logic [31:0]      w_word, w_rd_data, w_wr_word;
    mem_resp_4B_t     w_resp, w_push_msg;
    logic             w_unused_addr_hi;

    assign w_accept         = memreq_val && memreq_rdy;
    assign w_deliver        = memresp_val && memresp_rdy;
    assign w_idx            = memreq_msg.addr[IDX_W+1:2];
    assign w_is_write       = (memreq_msg.type_ == MEM_TYPE_WRITE);
    assign w_word           = mem_q[w_idx];
    assign w_unused_addr_hi = ^memreq_msg.addr[31:IDX_W+2];

    // len==0 is a whole aligned word; otherwise len bytes from addr[1:0], clipped at lane 3
    always_comb begin
        w_lo      = (memreq_msg.len == 2'd0) ? 0 : int'(memreq_msg.addr[1:0]);
        w_n       = (memreq_msg.len == 2'd0) ? 4 : int'(memreq_msg.len);
        w_rd_data = '0;
        w_wr_word = w_word;
        for (int i = 0; i < 4; i++) begin
            if (i >= w_lo && i < w_lo + w_n) begin
                w_rd_data[8*(i-w_lo) +: 8] = w_word[8*i +: 8];
                w_wr_word[8*i +: 8]        = memreq_msg.data[8*(i-w_lo) +: 8];
            end
        end
    end

    always_comb begin
        w_resp        = '0;
        w_resp.type_  = memreq_msg.type_;
        w_resp.opaque = memreq_msg.opaque;
        w_resp.len    = memreq_msg.len;
        w_resp.data   = w_is_write ? 32'd0 : w_rd_data;
    end

    // Backing store is deliberately not reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (w_accept && w_is_write) begin
            mem_q[w_idx] <= w_wr_word;
        end
    end

    generate
        if (p_latency == 1) begin : g_direct
            assign w_push     = w_accept;
            assign w_push_msg = w_resp;
        end else begin : g_pipe
            logic [p_latency-2:0] vld_q;
            mem_resp_4B_t         msg_q [p_latency-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= '0;
                    for (int s = 0; s < p_latency - 1; s++) begin
                        msg_q[s] <= '0;
                    end
                end else begin
                    vld_q[0] <= w_accept;
                    msg_q[0] <= w_resp;
                    for (int s = 1; s < p_latency - 1; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        msg_q[s] <= msg_q[s-1];
                    end
                end
            end

            assign w_push     = vld_q[p_latency-2];
            assign w_push_msg = msg_q[p_latency-2];
        end
    endgenerate

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= w_push_msg;
        end
    end

    always_comb begin
        wr_ptr_d      = w_push    ? f_next(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = w_deliver ? f_next(rd_ptr_q) : rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        if (w_push && !w_deliver) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_deliver) begin
            count_d = count_q - 1'b1;
        end
        if (w_accept && !w_deliver) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!w_accept && w_deliver) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            rdy_en_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            rdy_en_q      <= 1'b1;
        end
    end

    // Outputs depend on registered state only; the message is zeroed when nothing is pending
    assign memresp_val = (count_q != '0);
    assign memresp_msg = memresp_val ? fifo_q[rd_ptr_q] : '0;
    assign memreq_rdy  = rdy_en_q && (outstanding_q < c_DEPTH);

endmodule

`default_nettype wire

// File: tb/tb_lab3_mem_responder.sv
// ============================================================================
// tb_lab3_mem_responder : directed + randomized check against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lab3_mem_responder;
    import lab3_mem_pkg::*;

    localparam int NW    = 256;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset;
    logic         memreq_val;
    logic         memreq_rdy;
    mem_req_4B_t  req;
    logic         memresp_val;
    logic         memresp_rdy;
    mem_resp_4B_t memresp_msg;

    lab3_mem_responder #(
        .p_num_words   (NW),
        .p_latency     (LAT),
        .p_queue_depth (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (req),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mem_resp_4B_t msg;
        int           due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mref [NW];
    logic [31:0] got_data [256];
    int          cyc = 0;
    bit          rdy_en = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference: word store, byte lanes from the request rules, response due LAT cycles later
    task automatic model_accept();
        exp_t        e;
        int          idx, lo, n;
        logic [31:0] w, d;
        idx = int'((req.addr >> 2) % NW);
        n   = (req.len == 2'd0) ? 4 : int'(req.len);
        lo  = (req.len == 2'd0) ? 0 : int'(req.addr % 4);
        w   = mref[idx];
        d   = '0;
        for (int k = 0; k < n; k++) begin
            if (lo + k < 4) begin
                if (req.type_ == MEM_TYPE_WRITE) w[8*(lo+k) +: 8] = req.data[8*k +: 8];
                else                             d[8*k +: 8]      = w[8*(lo+k) +: 8];
            end
        end
        if (req.type_ == MEM_TYPE_WRITE) begin
            mref[idx] = w;
            d = '0;
        end
        e.msg        = '0;
        e.msg.type_  = req.type_;
        e.msg.opaque = req.opaque;
        e.msg.len    = req.len;
        e.msg.data   = d;
        e.due        = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic tick(output bit acc);
        bit exp_val, exp_rdy, hs;
        @(negedge clk);
        exp_rdy = rdy_en && (q.size() < DEPTH);
        exp_val = (q.size() > 0) && (q[0].due <= cyc);
        check_eq("req_rdy", 64'(memreq_rdy), 64'(exp_rdy));
        check_eq("resp_val", 64'(memresp_val), 64'(exp_val));
        if (memresp_val && exp_val) check_eq("resp_msg", 64'(memresp_msg), 64'(q[0].msg));
        hs  = memresp_val && memresp_rdy;
        acc = memreq_val && memreq_rdy;
        if (hs) begin
            got_data[memresp_msg.opaque] = memresp_msg.data;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (acc) model_accept();
        @(posedge clk);
        cyc++;
        rdy_en = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        memreq_val = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic send(input logic [2:0] t, input logic [31:0] a, input logic [1:0] l,
                        input logic [31:0] d, input logic [7:0] op);
        bit acc;
        int c;
        req.type_  = t;
        req.addr   = a;
        req.len    = l;
        req.data   = d;
        req.opaque = op;
        memreq_val = 1'b1;
        acc = 1'b0;
        c   = 0;
        while (!acc && c < 50) begin
            tick(acc);
            c++;
        end
        check_eq("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        bit acc;
        int c;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b1;
        c = 0;
        while (q.size() > 0 && c < 100) begin
            tick(acc);
            c++;
        end
        check_eq("drain_done", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        memreq_val = 1'b0;
        #1;
        check_eq("rst_async_val", 64'(memresp_val), 64'd0);
        check_eq("rst_async_rdy", 64'(memreq_rdy), 64'd0);
        q.delete();
        rdy_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_rdy", 64'(memreq_rdy), 64'd0);
            check_eq("rst_val", 64'(memresp_val), 64'd0);
            check_eq("rst_msg", 64'(memresp_msg), 64'd0);
            @(posedge clk);
            cyc++;
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int k, t0;
        reset       = 1'b1;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b1;
        req         = '0;
        for (int i = 0; i < 256; i++) got_data[i] = 32'hFFFF_FFFF;
        #1;
        do_reset();

        for (int w = 0; w < 16; w++) send(MEM_TYPE_WRITE, 32'(w * 4), 2'd0, $urandom, 8'(8'hE0 + w));
        drain();

        send(MEM_TYPE_WRITE, 32'h1000, 2'd0, 32'hDEAD_BEEF, 8'h01);
        send(MEM_TYPE_READ,  32'h1000, 2'd0, 32'h0,        8'h02);
        drain();
        check_eq("wr_ack_data", 64'(got_data[8'h01]), 64'h0);
        check_eq("rd_after_wr", 64'(got_data[8'h02]), 64'hDEAD_BEEF);

        t0 = cyc;
        for (int i = 0; i < 8; i++) send(MEM_TYPE_READ, 32'(i * 4), 2'd0, 32'h0, 8'(i));
        check_eq("stream_cycles", 64'(cyc - t0), 64'd8);
        drain();

        memresp_rdy = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            req.type_ = MEM_TYPE_READ; req.addr = 32'(k * 4); req.len = 2'd0;
            req.data = '0; req.opaque = 8'(8'h20 + k); memreq_val = 1'b1;
            tick(acc);
            if (acc) k++;
        end
        check_eq("bp_accepted", 64'(k), 64'd4);
        memresp_rdy = 1'b1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            req.addr = 32'(k * 4); req.opaque = 8'(8'h20 + k);
            tick(acc);
            if (acc) k++;
        end
        check_eq("bp_all_accepted", 64'(k), 64'd6);
        drain();

        send(MEM_TYPE_WRITE, 32'h2000, 2'd0, 32'h1122_3344, 8'h30);
        send(MEM_TYPE_WRITE, 32'h2002, 2'd1, 32'h0000_00AB, 8'h31);
        send(MEM_TYPE_READ,  32'h2000, 2'd0, 32'h0, 8'h32);
        send(MEM_TYPE_READ,  32'h2002, 2'd2, 32'h0, 8'h33);
        send(MEM_TYPE_READ,  32'h2000 + 32'(4 * NW), 2'd0, 32'h0, 8'h34);
        drain();
        check_eq("sub_word_rd", 64'(got_data[8'h32]), 64'h11AB_3344);
        check_eq("sub_half_rd", 64'(got_data[8'h33]), 64'h0000_11AB);
        check_eq("alias_rd",    64'(got_data[8'h34]), 64'h11AB_3344);

        memresp_rdy = 1'b0;
        send(MEM_TYPE_WRITE, 32'h40, 2'd0, 32'hCAFE_F00D, 8'h40);
        send(MEM_TYPE_READ,  32'h0,  2'd0, 32'h0, 8'h41);
        send(MEM_TYPE_READ,  32'h4,  2'd0, 32'h0, 8'h42);
        idle(3);
        check_eq("pre_rst_val", 64'(memresp_val), 64'd1);
        do_reset();
        memresp_rdy = 1'b1;
        idle(6);
        check_eq("no_stale_41", 64'(got_data[8'h41]), 64'hFFFF_FFFF);
        check_eq("no_stale_42", 64'(got_data[8'h42]), 64'hFFFF_FFFF);
        send(MEM_TYPE_READ, 32'h40, 2'd0, 32'h0, 8'h43);
        drain();
        check_eq("kept_write", 64'(got_data[8'h43]), 64'hCAFE_F00D);

        for (int c = 0; c < 400; c++) begin
            memreq_val  = ($urandom_range(0, 3) != 0);
            req.type_   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7))
                                                      : 3'($urandom_range(0, 1));
            req.addr    = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
                          | 32'($urandom_range(0, 3));
            req.len     = 2'($urandom_range(0, 3));
            req.data    = $urandom;
            req.opaque  = 8'($urandom_range(0, 255));
            memresp_rdy = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
